pm_matrix_responder: RTL and testbench
======================================

Name: pm_matrix_responder

Overview:
- Pixel-matrix-side responder for the SoC pixel-matrix control interface (slave end).
- Implements a column of PIXELS pixels. Each pixel has a CNT_W-bit counter/shift register and a CFG_W-bit configuration latch, all driven by the control bits the CPU writes.
- Serves as the synthesizable matrix model for SoC simulation and as the RTL of the digital pixel column.
- Sits between the pm_ctrl register master and the shift-chain data pins (sh_din / sh_dout).

Parameters:
- PIXELS, 4: number of pixels in the chain.
- CNT_W, 8: counter/shift-register width per pixel; must be ≥ CFG_W.
- LFSR_SEED, 16'hACE1: reset value of the pattern LFSR; must be non-zero.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- pm_ctrl, input, soc_pm_ctrl.slave: control bits; res and shB are ignored.
- hit_i, input, PIXELS: per-pixel hit pulses; asynchronous to clk.
- sh_din, input, 1: serial data into pixel 0, bit 0.
- sh_dout, output, 1: serial data out; equals pixel[PIXELS-1] counter bit CNT_W-1.
- mask_o, output, PIXELS: per-pixel strobe-mask bit (cfg bit 0).
- cnt_o, output, PIXELS*CNT_W: flattened counters, pixel 0 in the LSBs; for debug and bench use.

Behaviour:
- Reset (async, rst=1): all counters 0, all cfg 0, LFSR=LFSR_SEED, all edge-history flops 0, hit synchronisers 0. Consequently sh_dout=0, mask_o=0, cnt_o=0.
- Edge detection: clkSh, strobe, gate and write_cfg are registered once. An edge is the current value versus the registered value. The action occurs on the clk edge following the cycle in which the edge is seen. Latency from the input change to the updated register is 1 cycle.
- hit_i: 2-flop synchroniser followed by rising-edge detect. Latency from hit assertion to counter update is 3 cycles.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk cycle.
- Shift mode (shA=1):
  - Each clkSh rising edge shifts the whole PIXELS*CNT_W chain by one bit.
  - The chain order is: sh_din goes into pixel0[0]; pixel i[CNT_W-1] goes into pixel i+1[0].
  - Hits, strobe and gate are ignored in this mode.
- Counter mode (shA=0):
  - Strobe rising edge: every pixel with cfg[0]=0 increments its counter by 1.
  - Synchronised hit rising edge on pixel i, while gate=1 and cfg_i[1]=0: pixel i increments by 1.
  - Strobe and hit on the same pixel in the same cycle: increment by 2.
  - Arithmetic is modulo 2^CNT_W.
  - Gate falling edge: every counter i loads LFSR[CNT_W-1:0] XOR i. This takes priority over strobe/hit increments in the same cycle.
  - clkSh is ignored in this mode.
- write_cfg rising edge, in either mode: cfg_i <= counter_i[CFG_W-1:0]. The counters are unchanged.
- If write_cfg coincides with a shift, cfg latches the pre-shift counter values.
- A shA change takes effect for edges detected from the next cycle onward. Its edge history is not cleared.
- Reset mid-shift: the chain clears to 0. Afterwards a partial shift sequence must be restarted by software.

Optional Feature:
- Macro: PM_CNT_SAT_EN.
- Defined: increments saturate at 2^CNT_W-1. A +2 increment from max-1 yields max.
- Not defined: increments wrap modulo 2^CNT_W.
- Shift and load paths are unaffected in both cases.

Decomposition:
- Package pm_pkg holds:
  - CFG_W=2;
  - CFG_MASK_STROBE=0 and CFG_MASK_HIT=1 bit indices;
  - LFSR taps constant;
  - typedef enum pm_mode_e {PM_COUNT, PM_SHIFT}.
- Sub-module pm_pixel holds one counter plus cfg latch, with inputs shift_en, shift_in, inc[1:0], load_en, load_val, cfg_wr.
- Top level holds the synchronisers, the edge detectors, the LFSR, and a generate loop that chains the pm_pixel instances.

Test Plan:
- Shift load/readback (PIXELS=4, CNT_W=8): shA=1; 32 clkSh pulses shifting 0x04,0x03,0x02,0x01, MSB first → cnt_o=32'h04030201. A further 32 pulses with sh_din=0 → sh_dout replays the same bit stream, and cnt_o=0.
- Config latch plus strobe masking: shift counters to {0x00,0x01,0x00,0x01}; pulse write_cfg → mask_o=4'b1010. Clear counters; shA=0; 3 strobe pulses → cnt_o=32'h00030003.
- Hit gating: gate=1; 5 hit pulses on pixel 2 → pixel2=5, others 0. Gate=0; 2 more hits → pixel2 stays 5. The gate fall loads LFSR^i into all pixels (compare against a reference LFSR model).
- Simultaneous strobe and hit on pixel 0 with counter 0xFE → 0x00 (wrap build) or 0xFF (PM_CNT_SAT_EN).
- Mode isolation: shA=1; strobe, hits and gate toggles → no counter change. shA=0 with clkSh pulses → no shift.
- Reset mid-operation: assert rst after 10 of 32 clkSh pulses → cnt_o=0, sh_dout=0 asynchronously; a full 32-pulse reload afterwards reads back correctly.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared constants and types for the pixel-matrix responder.
package pm_pkg;

   // Width of the per-pixel configuration latch and the meaning of its bits
   localparam int unsigned CFG_W           = 2;
   localparam int unsigned CFG_MASK_STROBE = 0;
   localparam int unsigned CFG_MASK_HIT    = 1;

   // Fibonacci taps 16,14,13,11 in right-shift form: state bits 0,2,3,5 feed bit 15
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef enum logic {
      PM_COUNT = 1'b0,
      PM_SHIFT = 1'b1
   } pm_mode_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {^(cur & LFSR_TAPS), cur[15:1]};
   endfunction

endpackage

// File: rtl/pm_matrix_responder_if.sv
// Pixel-matrix control bundle written by the pm_ctrl register master.
interface soc_pm_ctrl;

   logic res;
   logic shA;
   logic shB;
   logic clkSh;
   logic strobe;
   logic gate;
   logic write_cfg;

   modport master (output res, shA, shB, clkSh, strobe, gate, write_cfg);
   modport slave  (input  res, shA, shB, clkSh, strobe, gate, write_cfg);

endinterface

// File: rtl/pm_pixel.sv
// One pixel: counter/shift register plus configuration latch.
// Build option PM_CNT_SAT_EN makes increments saturate instead of wrapping.
module pm_pixel
   import pm_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             shift_in,
   input  logic [1:0]       inc,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_val,
   input  logic             cfg_wr,
   output logic [CNT_W-1:0] cnt,
   output logic [CFG_W-1:0] cfg
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0] inc_val;

`ifdef PM_CNT_SAT_EN
   // Extra bit catches the carry; any carry clamps to all-ones
   logic [CNT_W:0] sum;
   assign sum     = {1'b0, cnt_q} + (CNT_W + 1)'(inc);
   assign inc_val = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
   assign inc_val = cnt_q + CNT_W'(inc);
`endif

   // Next counter value: shift beats load beats increment
   always_comb begin
      cnt_d = cnt_q;
      if (shift_en) begin
         cnt_d = {cnt_q[CNT_W-2:0], shift_in};
      end else if (load_en) begin
         cnt_d = load_val;
      end else if (inc != 2'd0) begin
         cnt_d = inc_val;
      end
   end

   // Config latches the pre-update counter value
   always_comb begin
      cfg_d = cfg_q;
      if (cfg_wr) begin
         cfg_d = cnt_q[CFG_W-1:0];
      end
   end

   // Counter and config state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         cfg_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         cfg_q <= cfg_d;
      end
   end

   assign cnt = cnt_q;
   assign cfg = cfg_q;

endmodule

// File: rtl/pm_matrix_responder.sv
// Pixel-matrix responder: a column of pixels driven by the pm_ctrl bits.
// Control edges are detected against a one-cycle history; hits are synchronised first.
// Build option PM_CNT_SAT_EN (in pm_pixel) selects saturating increments.
module pm_matrix_responder
   import pm_pkg::*;
#(
   parameter int unsigned PIXELS    = 4,
   parameter int unsigned CNT_W     = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst,
   soc_pm_ctrl.slave               pm_ctrl,
   input  logic [PIXELS-1:0]       hit_i,
   input  logic                    sh_din,
   output logic                    sh_dout,
   output logic [PIXELS-1:0]       mask_o,
   output logic [PIXELS*CNT_W-1:0] cnt_o
);

   // res and shB have no function in this column
   logic unused_ctrl;
   assign unused_ctrl = ^{pm_ctrl.res, pm_ctrl.shB};

   logic        clksh_q, strobe_q, gate_q, wcfg_q;
   pm_mode_e    mode_q, mode_d;
   logic [15:0] lfsr_q;
   logic [PIXELS-1:0] hit_s1_q, hit_s2_q, hit_h_q;

   logic clksh_rise, strobe_rise, gate_fall, wcfg_rise;
   logic shift_en, load_en, count_en;
   logic [PIXELS-1:0] hit_rise;

   logic [CNT_W-1:0] cnt_arr   [PIXELS];
   logic [CFG_W-1:0] cfg_arr   [PIXELS];
   logic [1:0]       inc_arr   [PIXELS];
   logic             chain_in  [PIXELS];

   // Control edge history, mode register and hit synchronisers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clksh_q  <= 1'b0;
         strobe_q <= 1'b0;
         gate_q   <= 1'b0;
         wcfg_q   <= 1'b0;
         mode_q   <= PM_COUNT;
         hit_s1_q <= '0;
         hit_s2_q <= '0;
         hit_h_q  <= '0;
      end else begin
         clksh_q  <= pm_ctrl.clkSh;
         strobe_q <= pm_ctrl.strobe;
         gate_q   <= pm_ctrl.gate;
         wcfg_q   <= pm_ctrl.write_cfg;
         mode_q   <= mode_d;
         hit_s1_q <= hit_i;
         hit_s2_q <= hit_s1_q;
         hit_h_q  <= hit_s2_q;
      end
   end

   // Pattern LFSR free-runs every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   // Edge detection and mode-qualified enables
   always_comb begin
      mode_d      = pm_ctrl.shA ? PM_SHIFT : PM_COUNT;
      clksh_rise  = pm_ctrl.clkSh & ~clksh_q;
      strobe_rise = pm_ctrl.strobe & ~strobe_q;
      gate_fall   = ~pm_ctrl.gate & gate_q;
      wcfg_rise   = pm_ctrl.write_cfg & ~wcfg_q;
      hit_rise    = hit_s2_q & ~hit_h_q;
      shift_en    = (mode_q == PM_SHIFT) & clksh_rise;
      load_en     = (mode_q == PM_COUNT) & gate_fall;
      // A gate-fall load wins over any increment in the same cycle
      count_en    = (mode_q == PM_COUNT) & ~gate_fall;
   end

   // Per-pixel increment: strobe and hit each contribute one
   always_comb begin
      for (int i = 0; i < PIXELS; i++) begin
         inc_arr[i] = {1'b0, count_en & strobe_rise & ~cfg_arr[i][CFG_MASK_STROBE]}
                    + {1'b0, count_en & hit_rise[i] & pm_ctrl.gate & ~cfg_arr[i][CFG_MASK_HIT]};
      end
   end

   for (genvar g = 0; g < PIXELS; g++) begin : g_pixel
      if (g == 0) begin : g_head
         assign chain_in[g] = sh_din;
      end else begin : g_link
         assign chain_in[g] = cnt_arr[g-1][CNT_W-1];
      end

      pm_pixel #(
         .CNT_W (CNT_W)
      ) u_pixel (
         .clk      (clk),
         .rst      (rst),
         .shift_en (shift_en),
         .shift_in (chain_in[g]),
         .inc      (inc_arr[g]),
         .load_en  (load_en),
         .load_val (lfsr_q[CNT_W-1:0] ^ CNT_W'(g)),
         .cfg_wr   (wcfg_rise),
         .cnt      (cnt_arr[g]),
         .cfg      (cfg_arr[g])
      );

      assign cnt_o[g*CNT_W +: CNT_W] = cnt_arr[g];
      assign mask_o[g]               = cfg_arr[g][CFG_MASK_STROBE];
   end

   assign sh_dout = cnt_arr[PIXELS-1][CNT_W-1];

endmodule

// File: tb/tb_pm_matrix_responder.sv
// Self-checking bench for pm_matrix_responder against a flat-vector behavioural model.
module tb_pm_matrix_responder;

   localparam int unsigned PIXELS = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned NB     = PIXELS * CNT_W;
   localparam logic [15:0] SEED   = 16'hACE1;

   logic              clk = 1'b0;
   logic              rst;
   logic [PIXELS-1:0] hit_i;
   logic              sh_din;
   logic              sh_dout;
   logic [PIXELS-1:0] mask_o;
   logic [NB-1:0]     cnt_o;

   soc_pm_ctrl pm_ctrl ();

   pm_matrix_responder #(
      .PIXELS    (PIXELS),
      .CNT_W     (CNT_W),
      .LFSR_SEED (SEED)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pm_ctrl (pm_ctrl),
      .hit_i   (hit_i),
      .sh_din  (sh_din),
      .sh_dout (sh_dout),
      .mask_o  (mask_o),
      .cnt_o   (cnt_o)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: whole column as one flat vector, pixel 0 in the LSBs
   logic [NB-1:0]     m_cnt;
   logic [PIXELS-1:0] m_mask_strobe;
   logic [PIXELS-1:0] m_mask_hit;
   logic              m_shift;
   logic              m_gate;
   logic [15:0]       m_lfsr;

   // Reference LFSR: taps 16,14,13,11, shifting right, new bit enters at the top
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      int x;
      int fb;
      x  = int'(v);
      fb = ((x >> (16 - 16)) ^ (x >> (16 - 14)) ^ (x >> (16 - 13)) ^ (x >> (16 - 11))) & 1;
      return 16'((x >> 1) | (fb << 15));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= lfsr_step(m_lfsr);
   end

   function automatic logic [CNT_W-1:0] add_model(input logic [CNT_W-1:0] v, input int n);
      int s;
      s = int'(v) + n;
`ifdef PM_CNT_SAT_EN
      if (s > (1 << CNT_W) - 1) s = (1 << CNT_W) - 1;
`endif
      return CNT_W'(s % (1 << CNT_W));
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "/cnt"},  64'(cnt_o),  64'(m_cnt));
      check({tag, "/mask"}, 64'(mask_o), 64'(m_mask_strobe));
      check({tag, "/dout"}, 64'(sh_dout), 64'(m_cnt[NB-1]));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_mode(input logic sh);
      pm_ctrl.shA = sh;
      cyc(2);
      m_shift = sh;
   endtask

   task automatic shift_bit(input logic b);
      sh_din        = b;
      pm_ctrl.clkSh = 1'b1;
      cyc(1);
      pm_ctrl.clkSh = 1'b0;
      cyc(1);
      if (m_shift) m_cnt = {m_cnt[NB-2:0], b};
   endtask

   task automatic shift_word(input logic [NB-1:0] w);
      for (int k = NB - 1; k >= 0; k--) shift_bit(w[k]);
   endtask

   task automatic pulse_strobe();
      pm_ctrl.strobe = 1'b1;
      cyc(1);
      pm_ctrl.strobe = 1'b0;
      cyc(1);
      if (!m_shift)
         for (int i = 0; i < PIXELS; i++)
            if (!m_mask_strobe[i])
               m_cnt[i*CNT_W +: CNT_W] = add_model(m_cnt[i*CNT_W +: CNT_W], 1);
   endtask

   task automatic pulse_wcfg();
      pm_ctrl.write_cfg = 1'b1;
      cyc(1);
      pm_ctrl.write_cfg = 1'b0;
      cyc(1);
      for (int i = 0; i < PIXELS; i++) begin
         m_mask_strobe[i] = m_cnt[i*CNT_W + 0];
         m_mask_hit[i]    = m_cnt[i*CNT_W + 1];
      end
   endtask

   task automatic hit_pulse(input int p);
      hit_i[p] = 1'b1;
      cyc(2);
      hit_i[p] = 1'b0;
      cyc(2);
      if (!m_shift && m_gate && !m_mask_hit[p])
         m_cnt[p*CNT_W +: CNT_W] = add_model(m_cnt[p*CNT_W +: CNT_W], 1);
   endtask

   task automatic set_gate(input logic g);
      logic [15:0] lv;
      logic        fall;
      fall         = m_gate && !g && !m_shift;
      lv           = m_lfsr;
      pm_ctrl.gate = g;
      cyc(1);
      m_gate = g;
      if (fall)
         for (int i = 0; i < PIXELS; i++)
            m_cnt[i*CNT_W +: CNT_W] = lv[CNT_W-1:0] ^ CNT_W'(i);
      cyc(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [NB-1:0] w;
      int p;
      int n;

      rst               = 1'b1;
      hit_i             = '0;
      sh_din            = 1'b0;
      pm_ctrl.res       = 1'b0;
      pm_ctrl.shA       = 1'b0;
      pm_ctrl.shB       = 1'b0;
      pm_ctrl.clkSh     = 1'b0;
      pm_ctrl.strobe    = 1'b0;
      pm_ctrl.gate      = 1'b0;
      pm_ctrl.write_cfg = 1'b0;
      m_cnt = '0; m_mask_strobe = '0; m_mask_hit = '0; m_shift = 1'b0; m_gate = 1'b0;
      cyc(2);
      check_state("reset");
      rst = 1'b0;
      cyc(1);

      // Shift load and readback
      set_mode(1'b1);
      shift_word(32'h04030201);
      check("shift_fixed", 64'(cnt_o), 64'h04030201);
      w = NB'($urandom);
      shift_word(w);
      check_state("shift_rand");
      for (int k = 0; k < NB; k++) begin
         check("replay", 64'(sh_dout), 64'(w[NB-1-k]));
         shift_bit(1'b0);
      end
      check_state("drained");

      // Config latch and strobe masking
      shift_word(32'h01000100);
      pulse_wcfg();
      check("mask_latch", 64'(mask_o), 64'b1010);
      shift_word('0);
      set_mode(1'b0);
      repeat (3) pulse_strobe();
      check("strobe_masked", 64'(cnt_o), 64'h00030003);
      check_state("strobe");

      // Hit gating and gate-fall LFSR load
      set_mode(1'b1);
      shift_word('0);
      pulse_wcfg();
      set_mode(1'b0);
      set_gate(1'b1);
      p = $urandom_range(0, PIXELS - 1);
      n = $urandom_range(3, 6);
      repeat (n) hit_pulse(p);
      check("hits_gated_on", 64'(cnt_o[p*CNT_W +: CNT_W]), 64'(n));
      check_state("hits");
      set_gate(1'b0);
      check_state("gate_fall_load");
      repeat (2) hit_pulse(p);
      check_state("hits_gated_off");

      // Coincident strobe and hit on pixel 0 from max-1
      set_mode(1'b1);
      w = NB'($urandom);
      w[CNT_W-1:0] = 8'hFE;
      shift_word(w);
      set_mode(1'b0);
      set_gate(1'b1);
      hit_i[0] = 1'b1;
      cyc(2);
      pm_ctrl.strobe = 1'b1;
      cyc(1);
      pm_ctrl.strobe = 1'b0;
      hit_i[0] = 1'b0;
      cyc(2);
      m_cnt[0 +: CNT_W] = add_model(m_cnt[0 +: CNT_W], 2);
      for (int i = 1; i < PIXELS; i++)
         m_cnt[i*CNT_W +: CNT_W] = add_model(m_cnt[i*CNT_W +: CNT_W], 1);
`ifdef PM_CNT_SAT_EN
      check("plus2_edge", 64'(cnt_o[CNT_W-1:0]), 64'hFF);
`else
      check("plus2_edge", 64'(cnt_o[CNT_W-1:0]), 64'h00);
`endif
      check_state("plus2");

      // Mode isolation
      set_mode(1'b1);
      repeat (2) pulse_strobe();
      hit_pulse($urandom_range(0, PIXELS - 1));
      hit_pulse($urandom_range(0, PIXELS - 1));
      set_gate(1'b0);
      set_gate(1'b1);
      check_state("iso_shift_mode");
      set_mode(1'b0);
      repeat (4) shift_bit(1'($urandom));
      check_state("iso_count_mode");

      // Reset in the middle of a shift sequence
      set_mode(1'b1);
      repeat (10) shift_bit(1'($urandom));
      #2 rst = 1'b1;
      #1;
      check("rst_cnt",  64'(cnt_o),   64'h0);
      check("rst_dout", 64'(sh_dout), 64'h0);
      check("rst_mask", 64'(mask_o),  64'h0);
      m_cnt = '0; m_mask_strobe = '0; m_mask_hit = '0; m_shift = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      set_mode(1'b1);
      w = NB'($urandom);
      shift_word(w);
      check("reload", 64'(cnt_o), 64'(w));
      check_state("reload");

      // LFSR restarts from its seed after reset
      set_mode(1'b0);
      cyc($urandom_range(1, 20));
      set_gate(1'b0);
      check_state("post_reset_load");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
